// File: rtl/iq_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : iq_packer_if
// Description : Bundles the sample-input handshake and the memory write bus of
//               iq_packer.  The "slave" modport is the packer's view (consumes
//               samples, drives the memory bus); the "master" modport is the
//               view of whatever feeds samples and watches the memory bus.
//   in_valid  : sample strobe
//   in_i/in_q : NCH packed 24-bit I and Q words, ch0 in the LSBs
//   in_ready  : packer idle and able to accept in_valid
//   overflow  : sticky flag, a strobe was dropped
//   mem_*     : 48-bit write data, write address (MSB = page), write strobe
//   mem_block : page currently readable by the host (~mem_addr MSB)
//   page_done : one-cycle pulse when a page has been filled
// Revision    : 1.0 - initial release
// ============================================================================
interface iq_packer_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 8
) ();
    logic                  in_valid;
    logic [NCH*24-1:0]     in_i;
    logic [NCH*24-1:0]     in_q;
    logic                  in_ready;
    logic                  overflow;
    logic [47:0]           mem_data;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic                  mem_block;
    logic                  page_done;

    modport master (
        output in_valid, in_i, in_q,
        input  in_ready, overflow, mem_data, mem_addr, mem_wen, mem_block, page_done
    );

    modport slave (
        input  in_valid, in_i, in_q,
        output in_ready, overflow, mem_data, mem_addr, mem_wen, mem_block, page_done
    );
endinterface
`default_nettype wire

// File: rtl/iq_packer.sv
`default_nettype none
// ============================================================================
// Module      : iq_packer
// Description : Packs NCH channels of 24-bit I/Q samples into 48-bit memory
//               words written into a double-buffered (two-page) memory.
//               24-bit mode: one word {I,Q} per channel.
//               16-bit mode: halfwords I then Q per channel, three halfwords
//               per word, leftovers carried across strobes.
//               Optional macro IQ_PACKER_ROUND_EN selects round-half-up with
//               saturation for 16-bit halfwords instead of truncation.
// Ports       : clock   - sole clock
//               reset   - asynchronous active-high reset
//               rx_on   - packer enable (low = synchronous clear)
//               mode16  - 1 = 16-bit packing, latched only while rx_on = 0
//               bus     - iq_packer_if.slave (sample input + memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
module iq_packer #(
    parameter int NCH        = 2,
    parameter int PAGE_WORDS = 82,
    parameter int ADDR_W     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_on,
    input  logic        mode16,
    iq_packer_if.slave  bus
);

    // Each strobe is processed as 2*NCH one-cycle items: in 24-bit mode even
    // items strobe a word and odd items are the address-advance gap; in
    // 16-bit mode every item pushes one halfword into the packer.
    localparam int                NITEM     = 2 * NCH;
    localparam int                IDX_W     = $clog2(NITEM);
    localparam int                OFF_W     = ADDR_W - 1;
    localparam logic [IDX_W-1:0]  LAST_ITEM = IDX_W'(NITEM - 1);
    localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(PAGE_WORDS - 1);
    localparam logic [ADDR_W-1:0] PAGE_BASE = {1'b1, {OFF_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NCH*24-1:0]   cap_i_q, cap_i_d;
    logic [NCH*24-1:0]   cap_q_q, cap_q_d;
    logic                mode_q, mode_d;
    logic [47:0]         pk_q, pk_d;
    logic [1:0]          pk_cnt_q, pk_cnt_d;
    logic [47:0]         mem_data_q, mem_data_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic                page_done_q, page_done_d;
    logic                overflow_q, overflow_d;

    logic                w_accept;
    logic [IDX_W-1:0]    w_item;
    logic [NCH*24-1:0]   w_src_i;
    logic [NCH*24-1:0]   w_src_q;
    logic [23:0]         w_smp_i;
    logic [23:0]         w_smp_q;
    logic [23:0]         w_sample;
    logic [15:0]         w_half;

    // The first item is processed on the accept edge straight from the
    // inputs, so a strobe occupies exactly 2*NCH cycles.
    always_comb begin
        w_accept = (state_q == ST_READY) && bus.in_valid;
        w_src_i  = w_accept ? bus.in_i : cap_i_q;
        w_src_q  = w_accept ? bus.in_q : cap_q_q;
        w_item   = w_accept ? '0 : idx_q;
        w_smp_i  = w_src_i[24*int'(w_item >> 1) +: 24];
        w_smp_q  = w_src_q[24*int'(w_item >> 1) +: 24];
        w_sample = w_item[0] ? w_smp_q : w_smp_i;
    end

`ifdef IQ_PACKER_ROUND_EN
    // Round half-up on bit 7; only the positive full-scale code can overflow.
    always_comb begin
        if (w_sample[23:8] == 16'h7FFF) begin
            w_half = 16'h7FFF;
        end else begin
            w_half = w_sample[23:8] + {15'd0, w_sample[7]};
        end
    end
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^w_sample[7:0];
    assign w_half        = w_sample[23:8];
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cap_i_d     = cap_i_q;
        cap_q_d     = cap_q_q;
        mode_d      = mode_q;
        pk_d        = pk_q;
        pk_cnt_d    = pk_cnt_q;
        mem_data_d  = mem_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = 1'b0;
        page_done_d = 1'b0;
        overflow_d  = overflow_q;

        // Address advances on the edge that ends each write strobe.
        if (mem_wen_q) begin
            if (mem_addr_q[OFF_W-1:0] == LAST_OFF) begin
                mem_addr_d  = {~mem_addr_q[ADDR_W-1], {OFF_W{1'b0}}};
                page_done_d = 1'b1;
            end else begin
                mem_addr_d = {mem_addr_q[ADDR_W-1], mem_addr_q[OFF_W-1:0] + 1'b1};
            end
        end

        if (bus.in_valid && (state_q != ST_READY)) begin
            overflow_d = 1'b1;
        end

        if (w_accept) begin
            cap_i_d = bus.in_i;
            cap_q_d = bus.in_q;
        end

        if (w_accept || (state_q == ST_BUSY)) begin
            if (!mode_q) begin
                if (!w_item[0]) begin
                    mem_wen_d  = 1'b1;
                    mem_data_d = {w_smp_i, w_smp_q};
                end
            end else begin
                // Fills are always three pushes apart, so a fill can never
                // coincide with the previous word's strobe cycle.
                if (pk_cnt_q == 2'd2) begin
                    mem_wen_d  = 1'b1;
                    mem_data_d = {pk_q[47:16], w_half};
                    pk_d       = '0;
                    pk_cnt_d   = 2'd0;
                end else begin
                    if (pk_cnt_q == 2'd0) begin
                        pk_d[47:32] = w_half;
                    end else begin
                        pk_d[31:16] = w_half;
                    end
                    pk_cnt_d = pk_cnt_q + 2'd1;
                end
            end

            if (w_item == LAST_ITEM) begin
                state_d = ST_READY;
                idx_d   = '0;
            end else begin
                state_d = ST_BUSY;
                idx_d   = w_item + 1'b1;
            end
        end

        // Disable wins over everything: in-flight and partial words are lost.
        if (!rx_on) begin
            state_d     = ST_OFF;
            idx_d       = '0;
            mode_d      = mode16;
            pk_d        = '0;
            pk_cnt_d    = 2'd0;
            mem_addr_d  = PAGE_BASE;
            mem_wen_d   = 1'b0;
            page_done_d = 1'b0;
            overflow_d  = 1'b0;
        end else if (state_q == ST_OFF) begin
            state_d = ST_READY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            cap_i_q     <= '0;
            cap_q_q     <= '0;
            mode_q      <= 1'b0;
            pk_q        <= '0;
            pk_cnt_q    <= 2'd0;
            mem_data_q  <= '0;
            mem_addr_q  <= PAGE_BASE;
            mem_wen_q   <= 1'b0;
            page_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cap_i_q     <= cap_i_d;
            cap_q_q     <= cap_q_d;
            mode_q      <= mode_d;
            pk_q        <= pk_d;
            pk_cnt_q    <= pk_cnt_d;
            mem_data_q  <= mem_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            page_done_q <= page_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_READY);
    assign bus.overflow  = overflow_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_block = ~mem_addr_q[ADDR_W-1];
    assign bus.page_done = page_done_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_packer
// Description : Directed self-checking bench for iq_packer.  Two instances:
//               u_n2 (NCH=2) for 24-bit timing/overflow, u_n1 (NCH=1) for
//               page wrap, 16-bit packing, disable mid-pair, rounding and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx1 = 1'b0;
    logic rx2 = 1'b0;
    logic m1  = 1'b0;
    logic m2  = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef IQ_PACKER_ROUND_EN
    localparam logic [15:0] EXP_RND = 16'h1235;
`else
    localparam logic [15:0] EXP_RND = 16'h1234;
`endif

    always #5 clk = ~clk;

    iq_packer_if #(.NCH(2), .ADDR_W(8)) b2 ();
    iq_packer_if #(.NCH(1), .ADDR_W(8)) b1 ();

    iq_packer #(.NCH(2), .PAGE_WORDS(82), .ADDR_W(8)) u_n2 (
        .clock (clk),
        .reset (rst),
        .rx_on (rx2),
        .mode16(m2),
        .bus   (b2.slave)
    );

    iq_packer #(.NCH(1), .PAGE_WORDS(82), .ADDR_W(8)) u_n1 (
        .clock (clk),
        .reset (rst),
        .rx_on (rx1),
        .mode16(m1),
        .bus   (b1.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe1(input logic [23:0] i, input logic [23:0] q);
        b1.in_valid = 1'b1;
        b1.in_i     = i;
        b1.in_q     = q;
        tick();
        b1.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.in_valid = 1'b0; b1.in_i = '0; b1.in_q = '0;
        b2.in_valid = 1'b0; b2.in_i = '0; b2.in_q = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr",   b2.mem_addr,  64'h80);
        check("rst_data",   b2.mem_data,  64'h0);
        check("rst_wen",    b2.mem_wen,   64'h0);
        check("rst_ready",  b2.in_ready,  64'h0);
        check("rst_ovf",    b2.overflow,  64'h0);
        check("rst_pdone",  b2.page_done, 64'h0);
        check("rst_block",  b2.mem_block, 64'h0);
        rst = 1'b0;
        tick();

        // ---------------- NCH=2, 24-bit ----------------
        rx2 = 1'b1;
        tick();
        check("n2_ready_on", b2.in_ready, 64'h1);
        b2.in_valid = 1'b1;
        b2.in_i = {24'h654321, 24'h123456};
        b2.in_q = {24'hFEDCBA, 24'hABCDEF};
        tick();
        b2.in_valid = 1'b0;
        check("n2_w0_wen",   b2.mem_wen,  64'h1);
        check("n2_w0_data",  b2.mem_data, 64'h123456ABCDEF);
        check("n2_w0_addr",  b2.mem_addr, 64'h80);
        check("n2_busy",     b2.in_ready, 64'h0);
        tick();
        check("n2_gap_wen",  b2.mem_wen,  64'h0);
        check("n2_gap_addr", b2.mem_addr, 64'h81);
        tick();
        check("n2_w1_wen",   b2.mem_wen,  64'h1);
        check("n2_w1_data",  b2.mem_data, 64'h654321FEDCBA);
        check("n2_w1_addr",  b2.mem_addr, 64'h81);
        tick();
        check("n2_end_wen",  b2.mem_wen,  64'h0);
        check("n2_end_addr", b2.mem_addr, 64'h82);
        check("n2_ready4",   b2.in_ready, 64'h1);

        // ---------------- overflow ----------------
        b2.in_valid = 1'b1;
        b2.in_i = {24'h222222, 24'h111111};
        b2.in_q = {24'h444444, 24'h333333};
        tick();
        check("ov_w0_data",  b2.mem_data, 64'h111111333333);
        b2.in_i = {24'hDEAD00, 24'hBEEF00};
        b2.in_q = {24'hDEAD11, 24'hBEEF11};
        tick();
        b2.in_valid = 1'b0;
        check("ov_flag",     b2.overflow, 64'h1);
        check("ov_gap_addr", b2.mem_addr, 64'h83);
        tick();
        check("ov_w1_data",  b2.mem_data, 64'h222222444444);
        check("ov_w1_addr",  b2.mem_addr, 64'h83);
        tick();
        check("ov_ready",    b2.in_ready, 64'h1);
        check("ov_sticky",   b2.overflow, 64'h1);
        rx2 = 1'b0;
        tick();
        check("ov_clear",    b2.overflow, 64'h0);
        check("off_addr",    b2.mem_addr, 64'h80);
        check("off_ready",   b2.in_ready, 64'h0);

        // ---------------- NCH=1, 24-bit page wrap ----------------
        rx1 = 1'b1;
        tick();
        for (int k = 0; k < 83; k++) begin
            check($sformatf("pg_ready_%0d", k), b1.in_ready, 64'h1);
            strobe1(24'(k), 24'(k + 1000));
            check($sformatf("pg_addr_%0d", k), b1.mem_addr, (k < 82) ? 64'(8'h80 + k) : 64'h0);
            check($sformatf("pg_data_%0d", k), b1.mem_data, {16'h0, 24'(k), 24'(k + 1000)});
            tick();
            check($sformatf("pg_done_%0d", k), b1.page_done, (k == 81) ? 64'h1 : 64'h0);
        end
        check("pg_block",    b1.mem_block, 64'h1);
        check("pg_addr_end", b1.mem_addr,  64'h01);

        // ---------------- NCH=1, 16-bit packing ----------------
        rx1 = 1'b0;
        m1  = 1'b1;
        tick();
        rx1 = 1'b1;
        tick();
        check("p16_ready", b1.in_ready, 64'h1);
        strobe1(24'h11113C, 24'h22223C);
        check("p16_nowen0", b1.mem_wen, 64'h0);
        tick();
        check("p16_ready2", b1.in_ready, 64'h1);
        strobe1(24'h33333C, 24'h44443C);
        check("p16_w0_wen",  b1.mem_wen,  64'h1);
        check("p16_w0_data", b1.mem_data, 64'h111122223333);
        check("p16_w0_addr", b1.mem_addr, 64'h80);
        tick();
        check("p16_gap_addr", b1.mem_addr, 64'h81);
        strobe1(24'h55553C, 24'h66663C);
        check("p16_nowen1", b1.mem_wen, 64'h0);
        tick();
        check("p16_w1_wen",  b1.mem_wen,  64'h1);
        check("p16_w1_data", b1.mem_data, 64'h444455556666);
        check("p16_w1_addr", b1.mem_addr, 64'h81);

        // ---------------- disable between the two words of a pair ----------------
        strobe1(24'h777701, 24'h888802);
        check("dis_addr0", b1.mem_addr, 64'h82);
        tick();
        strobe1(24'h999903, 24'hAAAA04);
        check("dis_w_data", b1.mem_data, 64'h777788889999);
        check("dis_w_addr", b1.mem_addr, 64'h82);
        tick();
        check("dis_addr1", b1.mem_addr, 64'h83);
        rx1 = 1'b0;
        tick();
        check("dis_addr",  b1.mem_addr, 64'h80);
        check("dis_ready", b1.in_ready, 64'h0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("dis_wen_%0d", c), b1.mem_wen, 64'h0);
            tick();
        end
        rx1 = 1'b1;
        tick();
        strobe1(24'hBBBB05, 24'hCCCC06);
        tick();
        strobe1(24'hDDDD07, 24'hEEEE08);
        check("rst_w_wen",  b1.mem_wen,  64'h1);
        check("rst_w_data", b1.mem_data, 64'hBBBBCCCCDDDD);
        check("rst_w_addr", b1.mem_addr, 64'h80);
        tick();

        // ---------------- halfword rounding / truncation ----------------
        strobe1(24'h7FFF80, 24'h123480);
        check("rnd_nowen", b1.mem_wen, 64'h0);
        tick();
        check("rnd_wen",  b1.mem_wen,  64'h1);
        check("rnd_data", b1.mem_data, {16'h0, 16'hEEEE, 16'h7FFF, EXP_RND});
        check("rnd_addr", b1.mem_addr, 64'h81);

        // ---------------- asynchronous reset ----------------
        rst = 1'b1;
        #1;
        check("ar_addr",  b1.mem_addr, 64'h80);
        check("ar_data",  b1.mem_data, 64'h0);
        check("ar_wen",   b1.mem_wen,  64'h0);
        check("ar_ready", b1.in_ready, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_ready_on", b1.in_ready, 64'h1);
        check("ar_addr_on",  b1.mem_addr, 64'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
